// File: rtl/npu_ctrl_pkg.sv
// Shared encodings for the NPU control sequencer: state codes, control-word bit positions, PISO size.
// Pure declarations; no latency or flow control of its own.
package npu_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_WAIT_IN = 3'd2;
  localparam logic [2:0] ST_MAC     = 3'd3;
  localparam logic [2:0] ST_RELU    = 3'd4;
  localparam logic [2:0] ST_PISO_LD = 3'd5;
  localparam logic [2:0] ST_WRITE   = 3'd6;
  localparam logic [2:0] ST_FINISH  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CLEAR   = ST_CLEAR,
    S_WAIT_IN = ST_WAIT_IN,
    S_MAC     = ST_MAC,
    S_RELU    = ST_RELU,
    S_PISO_LD = ST_PISO_LD,
    S_WRITE   = ST_WRITE,
    S_FINISH  = ST_FINISH
  } state_t;

  // CON_SIG bit positions
  localparam int CS_EN_BUF_IN    = 15;
  localparam int CS_CLR_BUF_IN   = 14;
  localparam int CS_EN_MAC       = 13;
  localparam int CS_RST_MAC      = 12;
  localparam int CS_EN_RELU      = 11;
  localparam int CS_SHIFT_OUT    = 10;
  localparam int CS_EN_PISO_OUT  = 9;
  localparam int CS_CLR_PISO_OUT = 8;
  localparam int CS_WR_EN        = 7;

  // SSFR bit positions
  localparam int SF_SEL_OUT_LSB = 13;
  localparam int SF_BYPASS1     = 12;
  localparam int SF_BYPASS2     = 11;
  localparam int SF_EN_COMP     = 10;
  localparam int SF_RST_COMP    = 9;
  localparam int SF_EN_FIFO     = 8;
  localparam int SF_RST_FIFO    = 7;

  localparam int PISO_BYTES = 4;
  localparam int BYTE_W     = $clog2(PISO_BYTES);

endpackage

// File: rtl/npu_ctrl_word_pack.sv
// Packs named datapath strobes into the CON_SIG / SSFR words; purely combinational, zero latency.
// No flow control; unused low bits are tied to zero.
module npu_ctrl_word_pack
  import npu_ctrl_pkg::*;
(
  input  logic        i_en_buf_in,
  input  logic        i_clr_buf_in,
  input  logic        i_en_mac,
  input  logic        i_rst_mac,
  input  logic        i_en_relu,
  input  logic        i_shift_out,
  input  logic        i_en_piso_out,
  input  logic        i_clr_piso_out,
  input  logic        i_wr_en,
  input  logic [2:0]  i_sel_out,
  input  logic        i_bypass1,
  input  logic        i_bypass2,
  input  logic        i_en_comp,
  input  logic        i_rst_comp,
  input  logic        i_en_fifo,
  input  logic        i_rst_fifo,
  output logic [15:0] o_con_sig,
  output logic [15:0] o_ssfr
);

  always_comb begin
    o_con_sig                  = '0;
    o_con_sig[CS_EN_BUF_IN]    = i_en_buf_in;
    o_con_sig[CS_CLR_BUF_IN]   = i_clr_buf_in;
    o_con_sig[CS_EN_MAC]       = i_en_mac;
    o_con_sig[CS_RST_MAC]      = i_rst_mac;
    o_con_sig[CS_EN_RELU]      = i_en_relu;
    o_con_sig[CS_SHIFT_OUT]    = i_shift_out;
    o_con_sig[CS_EN_PISO_OUT]  = i_en_piso_out;
    o_con_sig[CS_CLR_PISO_OUT] = i_clr_piso_out;
    o_con_sig[CS_WR_EN]        = i_wr_en;

    o_ssfr                        = '0;
    o_ssfr[SF_SEL_OUT_LSB +: 3]   = i_sel_out;
    o_ssfr[SF_BYPASS1]            = i_bypass1;
    o_ssfr[SF_BYPASS2]            = i_bypass2;
    o_ssfr[SF_EN_COMP]            = i_en_comp;
    o_ssfr[SF_RST_COMP]           = i_rst_comp;
    o_ssfr[SF_EN_FIFO]            = i_en_fifo;
    o_ssfr[SF_RST_FIFO]           = i_rst_fifo;
  end

endmodule

// File: rtl/npu_layer_sequencer.sv
// One-pass NPU control FSM: clear, NACC input/MAC pairs, ReLU, PISO load, 4 byte writes; 2N+8 cycles unstalled.
// Input beats use IN_VALID/IN_READY; each FIFO_FULL cycle in WRITE holds the shift; ABORT returns to IDLE.
module npu_layer_sequencer
  import npu_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLKEXT,
  input  logic             RST_GLO,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] CFG_NACC,
  input  logic             CFG_BYPASS1,
  input  logic             CFG_BYPASS2,
  input  logic             CFG_COMP_EN,
  input  logic             CFG_FIFO_CLR,
  input  logic [2:0]       CFG_SEL_OUT,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             FIFO_FULL,
  output logic [15:0]      CON_SIG,
  output logic [15:0]      SSFR,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [CNT_W-1:0]  ACC_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BYTE_W-1:0] BYTE_ONE  = {{(BYTE_W-1){1'b0}}, 1'b1};
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PISO_BYTES - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_acc_cnt;
  logic [BYTE_W-1:0] r_byte_cnt;
  logic [CNT_W-1:0]  r_nacc;
  logic [2:0]        r_sel_out;
  logic              r_bypass1;
  logic              r_bypass2;
  logic              r_comp_en;
  logic              r_fifo_clr;

  logic [CNT_W-1:0]  w_acc_last;
  logic              w_clear;
  logic              w_wait_in;
  logic              w_mac;
  logic              w_relu;
  logic              w_piso_ld;
  logic              w_write_go;

  // NACC of zero behaves as a single beat.
  assign w_acc_last = (r_nacc == '0) ? '0 : (r_nacc - ACC_ONE);

  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      r_state    <= S_IDLE;
      r_acc_cnt  <= '0;
      r_byte_cnt <= '0;
      r_nacc     <= '0;
      r_sel_out  <= '0;
      r_bypass1  <= 1'b0;
      r_bypass2  <= 1'b0;
      r_comp_en  <= 1'b0;
      r_fifo_clr <= 1'b0;
    end else if (ABORT) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_nacc     <= CFG_NACC;
            r_sel_out  <= CFG_SEL_OUT;
            r_bypass1  <= CFG_BYPASS1;
            r_bypass2  <= CFG_BYPASS2;
            r_comp_en  <= CFG_COMP_EN;
            r_fifo_clr <= CFG_FIFO_CLR;
            r_state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_acc_cnt <= '0;
          r_state   <= S_WAIT_IN;
        end
        S_WAIT_IN: begin
          if (IN_VALID) r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc_cnt <= r_acc_cnt + ACC_ONE;
          r_state   <= (r_acc_cnt == w_acc_last) ? S_RELU : S_WAIT_IN;
        end
        S_RELU: r_state <= S_PISO_LD;
        S_PISO_LD: begin
          r_byte_cnt <= '0;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          if (!FIFO_FULL) begin
            r_byte_cnt <= r_byte_cnt + BYTE_ONE;
            if (r_byte_cnt == BYTE_LAST) r_state <= S_FINISH;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign w_clear    = (r_state == S_CLEAR);
  assign w_wait_in  = (r_state == S_WAIT_IN);
  assign w_mac      = (r_state == S_MAC);
  assign w_relu     = (r_state == S_RELU);
  assign w_piso_ld  = (r_state == S_PISO_LD);
  assign w_write_go = (r_state == S_WRITE) && !FIFO_FULL;

  assign IN_READY = w_wait_in;
  assign BUSY     = (r_state != S_IDLE);
  assign DONE     = (r_state == S_FINISH);

  npu_ctrl_word_pack u_pack (
    .i_en_buf_in    (w_wait_in && IN_VALID),
    .i_clr_buf_in   (w_clear),
    .i_en_mac       (w_mac),
    .i_rst_mac      (w_clear),
    .i_en_relu      (w_relu),
    .i_shift_out    (w_write_go),
    .i_en_piso_out  (w_piso_ld),
    .i_clr_piso_out (w_clear),
    .i_wr_en        (w_write_go),
    .i_sel_out      (r_sel_out),
    .i_bypass1      (r_bypass1),
    .i_bypass2      (r_bypass2),
    .i_en_comp      (w_relu && r_comp_en),
    .i_rst_comp     (w_clear),
    .i_en_fifo      (1'b1),
    .i_rst_fifo     (w_clear && r_fifo_clr),
    .o_con_sig      (CON_SIG),
    .o_ssfr         (SSFR)
  );

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Directed bench for npu_layer_sequencer; cycle k is the k-th clock period after the START-accept edge.
module tb_npu_layer_sequencer;

  logic        CLKEXT = 1'b0;
  logic        RST_GLO;
  logic        START;
  logic        ABORT;
  logic [7:0]  CFG_NACC;
  logic        CFG_BYPASS1;
  logic        CFG_BYPASS2;
  logic        CFG_COMP_EN;
  logic        CFG_FIFO_CLR;
  logic [2:0]  CFG_SEL_OUT;
  logic        IN_VALID;
  logic        IN_READY;
  logic        FIFO_FULL;
  logic [15:0] CON_SIG;
  logic [15:0] SSFR;
  logic        BUSY;
  logic        DONE;

  int total = 0;
  int bad   = 0;

  npu_layer_sequencer #(.CNT_W(8)) dut (
    .CLKEXT       (CLKEXT),
    .RST_GLO      (RST_GLO),
    .START        (START),
    .ABORT        (ABORT),
    .CFG_NACC     (CFG_NACC),
    .CFG_BYPASS1  (CFG_BYPASS1),
    .CFG_BYPASS2  (CFG_BYPASS2),
    .CFG_COMP_EN  (CFG_COMP_EN),
    .CFG_FIFO_CLR (CFG_FIFO_CLR),
    .CFG_SEL_OUT  (CFG_SEL_OUT),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .FIFO_FULL    (FIFO_FULL),
    .CON_SIG      (CON_SIG),
    .SSFR         (SSFR),
    .BUSY         (BUSY),
    .DONE         (DONE)
  );

  always #5 CLKEXT = ~CLKEXT;

  // Expected CON_SIG for an unstalled pass with IN_VALID held high.
  function automatic logic [15:0] exp_con(input int c, input int n);
    int ne;
    ne = (n == 0) ? 1 : n;
    if (c == 1) return 16'h5100;
    if (c >= 2 && c <= 2*ne+1) return (c % 2 == 0) ? 16'h8000 : 16'h2000;
    if (c == 2*ne+2) return 16'h0800;
    if (c == 2*ne+3) return 16'h0200;
    if (c >= 2*ne+4 && c <= 2*ne+7) return 16'h0480;
    return 16'h0000;
  endfunction

  task automatic next_cycle();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic launch(input logic [7:0] nacc, input logic [2:0] sel, input logic b1,
                        input logic b2, input logic comp, input logic fclr);
    next_cycle();
    CFG_NACC = nacc; CFG_SEL_OUT = sel; CFG_BYPASS1 = b1; CFG_BYPASS2 = b2;
    CFG_COMP_EN = comp; CFG_FIFO_CLR = fclr;
    IN_VALID = 1'b1; FIFO_FULL = 1'b0; ABORT = 1'b0;
    START = 1'b1;
  endtask

  task automatic test_reset();
    RST_GLO = 1'b1; START = 0; ABORT = 0; IN_VALID = 0; FIFO_FULL = 0;
    CFG_NACC = 0; CFG_SEL_OUT = 0; CFG_BYPASS1 = 0; CFG_BYPASS2 = 0;
    CFG_COMP_EN = 0; CFG_FIFO_CLR = 0;
    #12;
    total++; if (CON_SIG !== 16'h0000) begin bad++; $display("FAIL reset_con got=%h exp=0000", CON_SIG); end
    total++; if (SSFR !== 16'h0100) begin bad++; $display("FAIL reset_ssfr got=%h exp=0100", SSFR); end
    total++; if ({IN_READY, BUSY, DONE} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {IN_READY, BUSY, DONE}); end
    @(negedge CLKEXT);
    RST_GLO = 1'b0;
    repeat (3) next_cycle();
    @(negedge CLKEXT);
    total++; if ({BUSY, CON_SIG, SSFR} !== {1'b0, 16'h0000, 16'h0100}) begin
      bad++; $display("FAIL idle_after_reset got=%b/%h/%h exp=0/0000/0100", BUSY, CON_SIG, SSFR);
    end
  endtask

  task automatic test_basic_pass();
    logic [15:0] es;
    launch(8'd4, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 1; c <= 18; c++) begin
      next_cycle();
      if (c == 1) START = 1'b0;
      @(negedge CLKEXT);
      es = (c == 1) ? 16'h0380 : (c == 10) ? 16'h0500 : 16'h0100;
      total++; if (CON_SIG !== exp_con(c, 4)) begin bad++; $display("FAIL basic_con cyc=%0d got=%h exp=%h", c, CON_SIG, exp_con(c, 4)); end
      total++; if (SSFR !== es) begin bad++; $display("FAIL basic_ssfr cyc=%0d got=%h exp=%h", c, SSFR, es); end
      total++; if (DONE !== (c == 16)) begin bad++; $display("FAIL basic_done cyc=%0d got=%b", c, DONE); end
      total++; if (BUSY !== (c <= 16)) begin bad++; $display("FAIL basic_busy cyc=%0d got=%b", c, BUSY); end
      total++; if (IN_READY !== (c >= 2 && c <= 8 && c % 2 == 0)) begin bad++; $display("FAIL basic_in_ready cyc=%0d got=%b", c, IN_READY); end
    end
  endtask

  task automatic test_nacc_zero();
    int macs = 0;
    int done_cyc = -1;
    launch(8'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      next_cycle();
      if (c == 1) START = 1'b0;
      @(negedge CLKEXT);
      if (CON_SIG[13]) macs++;
      if (DONE && done_cyc < 0) done_cyc = c;
      total++; if (CON_SIG !== exp_con(c, 0)) begin bad++; $display("FAIL nacc0_con cyc=%0d got=%h exp=%h", c, CON_SIG, exp_con(c, 0)); end
    end
    total++; if (macs != 1) begin bad++; $display("FAIL nacc0_mac_count got=%0d exp=1", macs); end
    total++; if (done_cyc != 10) begin bad++; $display("FAIL nacc0_done_cycle got=%0d exp=10", done_cyc); end
  endtask

  task automatic test_in_valid_gap();
    int done_cyc = -1;
    launch(8'd2, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      next_cycle();
      if (c == 1) START = 1'b0;
      IN_VALID = !(c >= 4 && c <= 6);
      @(negedge CLKEXT);
      if (DONE && done_cyc < 0) done_cyc = c;
      if (c >= 4 && c <= 7) begin
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL gap_in_ready cyc=%0d got=%b exp=1", c, IN_READY); end
        total++; if (CON_SIG[15] !== IN_VALID) begin bad++; $display("FAIL gap_en_buf cyc=%0d got=%b exp=%b", c, CON_SIG[15], IN_VALID); end
      end
      if (c == 8) begin
        total++; if (CON_SIG !== 16'h2000) begin bad++; $display("FAIL gap_mac cyc=8 got=%h exp=2000", CON_SIG); end
      end
    end
    IN_VALID = 1'b0;
    total++; if (done_cyc != 15) begin bad++; $display("FAIL gap_done_cycle got=%0d exp=15", done_cyc); end
  endtask

  task automatic test_fifo_stall();
    int wr = 0;
    int sh = 0;
    int done_cyc = -1;
    launch(8'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      next_cycle();
      if (c == 1) START = 1'b0;
      FIFO_FULL = (c <= 5) || (c >= 7 && c <= 11);
      @(negedge CLKEXT);
      if (CON_SIG[7]) wr++;
      if (CON_SIG[10]) sh++;
      if (DONE && done_cyc < 0) done_cyc = c;
      if (c == 6) begin
        total++; if (CON_SIG !== 16'h0480) begin bad++; $display("FAIL stall_first_write got=%h exp=0480", CON_SIG); end
      end
      if (c == 9) begin
        total++; if (CON_SIG !== 16'h0000) begin bad++; $display("FAIL stall_hold got=%h exp=0000", CON_SIG); end
      end
    end
    FIFO_FULL = 1'b0;
    total++; if (wr != 4) begin bad++; $display("FAIL stall_wr_count got=%0d exp=4", wr); end
    total++; if (sh != 4) begin bad++; $display("FAIL stall_shift_count got=%0d exp=4", sh); end
    total++; if (done_cyc != 15) begin bad++; $display("FAIL stall_done_cycle got=%0d exp=15", done_cyc); end
  endtask

  task automatic test_abort();
    int dones = 0;
    int done_cyc = -1;
    launch(8'd4, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      if (c == 1) START = 1'b0;
      ABORT = (c == 5);
      @(negedge CLKEXT);
      if (DONE) dones++;
      if (c == 5) begin
        total++; if (CON_SIG !== 16'h2000) begin bad++; $display("FAIL abort_in_mac got=%h exp=2000", CON_SIG); end
      end
      if (c == 6) begin
        total++; if ({BUSY, IN_READY, CON_SIG} !== {2'b00, 16'h0000}) begin
          bad++; $display("FAIL abort_idle got=%b%b/%h exp=00/0000", BUSY, IN_READY, CON_SIG);
        end
      end
    end
    total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    launch(8'd4, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      next_cycle();
      if (c == 1) START = 1'b0;
      @(negedge CLKEXT);
      if (DONE && done_cyc < 0) done_cyc = c;
      total++; if (CON_SIG !== exp_con(c, 4)) begin bad++; $display("FAIL abort_rerun_con cyc=%0d got=%h exp=%h", c, CON_SIG, exp_con(c, 4)); end
    end
    total++; if (done_cyc != 16) begin bad++; $display("FAIL abort_rerun_done got=%0d exp=16", done_cyc); end
  endtask

  task automatic test_shadow_cfg();
    launch(8'd1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      if (c == 1) START = 1'b0;
      if (c == 3) begin
        CFG_SEL_OUT = 3'b010; CFG_BYPASS1 = 1'b0; CFG_BYPASS2 = 1'b1; CFG_NACC = 8'd5;
      end
      START = (c == 4);
      @(negedge CLKEXT);
      total++; if (SSFR[15:12] !== 4'b1011) begin bad++; $display("FAIL shadow_ssfr cyc=%0d got=%b exp=1011", c, SSFR[15:12]); end
      if (c == 10) begin
        total++; if (DONE !== 1'b1) begin bad++; $display("FAIL shadow_done cyc=10 got=%b exp=1", DONE); end
      end
      if (c >= 11) begin
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL shadow_start_ignored cyc=%0d got=%b exp=0", c, BUSY); end
      end
    end
    total++; if (SSFR !== 16'hB100) begin bad++; $display("FAIL shadow_idle_ssfr got=%h exp=B100", SSFR); end
  endtask

  task automatic test_reset_mid_pass();
    int dones = 0;
    launch(8'd4, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 1) START = 1'b0;
    end
    #2;
    RST_GLO = 1'b1;
    #1;
    total++; if (CON_SIG !== 16'h0000) begin bad++; $display("FAIL midrst_con got=%h exp=0000", CON_SIG); end
    total++; if (SSFR !== 16'h0100) begin bad++; $display("FAIL midrst_ssfr got=%h exp=0100", SSFR); end
    total++; if ({IN_READY, BUSY, DONE} !== 3'b000) begin bad++; $display("FAIL midrst_flags got=%b exp=000", {IN_READY, BUSY, DONE}); end
    repeat (2) @(negedge CLKEXT);
    RST_GLO = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLKEXT);
      if (DONE) dones++;
    end
    total++; if (dones != 0 || BUSY !== 1'b0) begin bad++; $display("FAIL midrst_quiet got=%0d/%b exp=0/0", dones, BUSY); end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_nacc_zero();
    test_in_valid_gap();
    test_fifo_stall();
    test_abort();
    test_shadow_cfg();
    test_reset_mid_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
